// File: rtl/fpu_arbiter.sv
// Purpose: round-robin share of one fpu16 among NUM_REQ valid/ready requesters, one op in flight.
// Latency: ADD/SUB response ADD_LAT+2 cycles after accept; MUL one cycle after mulDone (or timeout).
// Backpressure: response held stable until i_rspReady; no new grant until the response is taken.
module fpu_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LAT     = 1,
  parameter int MUL_TIMEOUT = 64
) (
  input  logic                         i_clock,
  input  logic                         i_reset_L,
  input  logic [NUM_REQ-1:0]           i_reqValid,
  output logic [NUM_REQ-1:0]           o_reqReady,
  input  logic [NUM_REQ*16-1:0]        i_reqIn1,
  input  logic [NUM_REQ*16-1:0]        i_reqIn2,
  input  logic [NUM_REQ*2-1:0]         i_reqOp,
  output logic                         o_rspValid,
  input  logic                         i_rspReady,
  output logic [$clog2(NUM_REQ)-1:0]   o_rspId,
  output logic [15:0]                  o_rspData,
  output logic [4:0]                   o_rspFlags,
  output logic                         o_rspErr,
  output logic [15:0]                  o_fpuIn1,
  output logic [15:0]                  o_fpuIn2,
  output logic [1:0]                   o_fpuOp,
  output logic                         o_fpuStart,
  input  logic                         i_fpuMulDone,
  input  logic [15:0]                  i_fpuResult,
  input  logic [4:0]                   i_fpuFlags
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_MAX = (ADD_LAT > MUL_TIMEOUT) ? ADD_LAT : MUL_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // fpuOp_t encoding shared with fpu16
  localparam logic [1:0] FPU_ADD = 2'd0;
  localparam logic [1:0] FPU_SUB = 2'd1;
  localparam logic [1:0] FPU_MUL = 2'd2;

  // Canonical quiet NaN with the invalid flag, used for error responses
  localparam logic [15:0] ERR_DATA  = 16'h7E00;
  localparam logic [4:0]  ERR_FLAGS = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ADD,
    S_WAIT_MUL,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_lastGrant;
  logic [ID_W-1:0]   r_curId;
  logic [CNT_W-1:0]  r_cnt;
  logic [15:0]       r_fpuIn1;
  logic [15:0]       r_fpuIn2;
  logic [1:0]        r_fpuOp;
  logic              r_fpuStart;
  logic              r_rspValid;
  logic [ID_W-1:0]   r_rspId;
  logic [15:0]       r_rspData;
  logic [4:0]        r_rspFlags;
  logic              r_rspErr;

  logic [ID_W-1:0]   w_grantIdx;
  logic              w_grantVld;
  logic [ID_W-1:0]   w_cand;
  logic [15:0]       w_selIn1;
  logic [15:0]       w_selIn2;
  logic [1:0]        w_selOp;

  // Round-robin search: first valid requester after the last one granted, wrapping
  always_comb begin
    w_grantIdx = '0;
    w_grantVld = 1'b0;
    w_cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_lastGrant) + k) % NUM_REQ);
      if (!w_grantVld && i_reqValid[w_cand]) begin
        w_grantVld = 1'b1;
        w_grantIdx = w_cand;
      end
    end
  end

  assign w_selIn1 = i_reqIn1[int'(w_grantIdx)*16 +: 16];
  assign w_selIn2 = i_reqIn2[int'(w_grantIdx)*16 +: 16];
  assign w_selOp  = i_reqOp[int'(w_grantIdx)*2 +: 2];

  // One-hot grant offered only while idle; forced low while reset is asserted
  always_comb begin
    o_reqReady = '0;
    if (i_reset_L && (r_state == S_IDLE) && w_grantVld) begin
      o_reqReady[w_grantIdx] = 1'b1;
    end
  end

  // Sequencer: accept, issue to the FPU, wait for the result, hold the response
  always_ff @(posedge i_clock or negedge i_reset_L) begin
    if (!i_reset_L) begin
      r_state     <= S_IDLE;
      r_lastGrant <= ID_W'(NUM_REQ - 1);
      r_curId     <= '0;
      r_cnt       <= '0;
      r_fpuIn1    <= '0;
      r_fpuIn2    <= '0;
      r_fpuOp     <= FPU_ADD;
      r_fpuStart  <= 1'b0;
      r_rspValid  <= 1'b0;
      r_rspId     <= '0;
      r_rspData   <= '0;
      r_rspFlags  <= '0;
      r_rspErr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grantVld) begin
            r_fpuIn1    <= w_selIn1;
            r_fpuIn2    <= w_selIn2;
            r_fpuOp     <= w_selOp;
            r_curId     <= w_grantIdx;
            r_lastGrant <= w_grantIdx;
            // start is registered so it is high exactly during the ISSUE cycle
            r_fpuStart  <= (w_selOp == FPU_MUL);
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_fpuStart <= 1'b0;
          case (r_fpuOp)
            FPU_MUL: begin
              r_cnt   <= '0;
              r_state <= S_WAIT_MUL;
            end
            FPU_ADD, FPU_SUB: begin
              r_cnt   <= CNT_W'(ADD_LAT);
              r_state <= S_WAIT_ADD;
            end
            default: begin
              r_rspData  <= ERR_DATA;
              r_rspFlags <= ERR_FLAGS;
              r_rspErr   <= 1'b1;
              r_rspId    <= r_curId;
              r_rspValid <= 1'b1;
              r_state    <= S_RESP;
            end
          endcase
        end
        S_WAIT_ADD: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_rspData  <= i_fpuResult;
            r_rspFlags <= i_fpuFlags;
            r_rspErr   <= 1'b0;
            r_rspId    <= r_curId;
            r_rspValid <= 1'b1;
            r_state    <= S_RESP;
          end
        end
        S_WAIT_MUL: begin
          if (i_fpuMulDone) begin
            r_rspData  <= i_fpuResult;
            r_rspFlags <= i_fpuFlags;
            r_rspErr   <= 1'b0;
            r_rspId    <= r_curId;
            r_rspValid <= 1'b1;
            r_state    <= S_RESP;
          end else if (r_cnt == CNT_W'(MUL_TIMEOUT - 1)) begin
            // this cycle's increment would reach MUL_TIMEOUT: give up
            r_cnt      <= r_cnt + 1'b1;
            r_rspData  <= ERR_DATA;
            r_rspFlags <= ERR_FLAGS;
            r_rspErr   <= 1'b1;
            r_rspId    <= r_curId;
            r_rspValid <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (i_rspReady) begin
            r_rspValid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_fpuIn1   = r_fpuIn1;
  assign o_fpuIn2   = r_fpuIn2;
  assign o_fpuOp    = r_fpuOp;
  assign o_fpuStart = r_fpuStart;
  assign o_rspValid = r_rspValid;
  assign o_rspId    = r_rspId;
  assign o_rspData  = r_rspData;
  assign o_rspFlags = r_rspFlags;
  assign o_rspErr   = r_rspErr;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Purpose: scoreboard bench for fpu_arbiter with a behavioural fpu16 stand-in.
// Latency: expected response latency is carried in each scoreboard entry.
// Backpressure: rspReady driven always-on, stalled, or random per phase.
module tb_fpu_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int ADD_LAT     = 1;
  localparam int MUL_TIMEOUT = 64;
  localparam int ID_W        = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    reqValid;
  logic [NUM_REQ-1:0]    reqReady;
  logic [NUM_REQ*16-1:0] reqIn1, reqIn2;
  logic [NUM_REQ*2-1:0]  reqOp;
  logic                  rspValid, rspReady;
  logic [ID_W-1:0]       rspId;
  logic [15:0]           rspData;
  logic [4:0]            rspFlags;
  logic                  rspErr;
  logic [15:0]           fpuIn1, fpuIn2, fpuResult;
  logic [1:0]            fpuOp;
  logic                  fpuStart, fpuMulDone;
  logic [4:0]            fpuFlags;

  always #5 clk = ~clk;

  fpu_arbiter #(.NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT), .MUL_TIMEOUT(MUL_TIMEOUT)) dut (
    .i_clock(clk), .i_reset_L(rst_n),
    .i_reqValid(reqValid), .o_reqReady(reqReady),
    .i_reqIn1(reqIn1), .i_reqIn2(reqIn2), .i_reqOp(reqOp),
    .o_rspValid(rspValid), .i_rspReady(rspReady),
    .o_rspId(rspId), .o_rspData(rspData), .o_rspFlags(rspFlags), .o_rspErr(rspErr),
    .o_fpuIn1(fpuIn1), .o_fpuIn2(fpuIn2), .o_fpuOp(fpuOp), .o_fpuStart(fpuStart),
    .i_fpuMulDone(fpuMulDone), .i_fpuResult(fpuResult), .i_fpuFlags(fpuFlags)
  );

  // Stand-in FPU datapath: any distinctive function of the operands will do
  function automatic logic [15:0] fres(logic [15:0] a, logic [15:0] b, logic [1:0] op);
    return (a ^ {b[7:0], b[15:8]}) + {14'd0, op} + 16'h0101;
  endfunction
  function automatic logic [4:0] fflg(logic [15:0] a, logic [15:0] b, logic [1:0] op);
    return a[4:0] ^ b[12:8] ^ {3'b000, op};
  endfunction
  assign fpuResult = fres(fpuIn1, fpuIn2, fpuOp);
  assign fpuFlags  = fflg(fpuIn1, fpuIn2, fpuOp);

  typedef struct {
    int          id;
    logic [15:0] data;
    logic [4:0]  flags;
    logic        err;
    int          lat;
    int          nstart;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
  } exp_t;
  exp_t sb_q[$];

  // requester slots
  bit          has[NUM_REQ];
  bit          taken[NUM_REQ];
  logic [15:0] s_a[NUM_REQ];
  logic [15:0] s_b[NUM_REQ];
  logic [1:0]  s_op[NUM_REQ];
  int          s_d[NUM_REQ];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int rdy_mode = 1;
  bit noise_en = 0, withdraw_en = 0;
  bit busy = 0;
  int last = NUM_REQ - 1;
  int acc_cyc = 0, cur_starts = 0;
  bit hold_bad = 0;
  bit mul_active = 0;
  int mul_cnt = 0, mul_d = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference response derived from the operation's rules (d = mulDone delay, 0 = never)
  function automatic exp_t mk(int id, logic [15:0] a, logic [15:0] b, logic [1:0] op, int d);
    exp_t e;
    e.id = id; e.a = a; e.b = b; e.op = op;
    e.data = fres(a, b, op); e.flags = fflg(a, b, op); e.err = 1'b0;
    e.nstart = 0;
    if (op <= 2'd1) begin
      e.lat = 2 + ADD_LAT;
    end else if (op == 2'd2) begin
      e.nstart = 1;
      if (d >= 1 && d <= MUL_TIMEOUT) e.lat = d + 2;
      else begin e.lat = 2 + MUL_TIMEOUT; e.data = 16'h7E00; e.flags = 5'b10000; e.err = 1'b1; end
    end else begin
      e.lat = 2; e.data = 16'h7E00; e.flags = 5'b10000; e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic post(int i, logic [15:0] a, logic [15:0] b, logic [1:0] op, int d);
    s_a[i] = a; s_b[i] = b; s_op[i] = op; s_d[i] = d; has[i] = 1'b1;
  endtask

  function automatic bit any_has();
    for (int i = 0; i < NUM_REQ; i++) if (has[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (any_has() || busy || sb_q.size() != 0) begin
      @(posedge clk);
      t++;
      if (t > 2000) begin
        n_cmp++; n_bad++;
        $display("FAIL wait_idle: no completion after %0d cycles, queue=%0d", t, sb_q.size());
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(string name);
    check(name, {reqReady, rspValid, rspId, rspData, rspFlags, rspErr,
                 fpuIn1, fpuIn2, fpuOp, fpuStart}, 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Input driver: requester buses, response ready, FPU mulDone
  initial begin
    reqValid = '0; reqIn1 = '0; reqIn2 = '0; reqOp = '0; rspReady = 1'b0; fpuMulDone = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (taken[i]) begin has[i] = 1'b0; taken[i] = 1'b0; end
        else if (withdraw_en && has[i] && $urandom_range(0, 15) == 0) has[i] = 1'b0;
        reqValid[i] = has[i];
        if (has[i]) begin
          reqIn1[i*16 +: 16] = s_a[i]; reqIn2[i*16 +: 16] = s_b[i]; reqOp[i*2 +: 2] = s_op[i];
        end else begin
          reqIn1[i*16 +: 16] = 16'($urandom); reqIn2[i*16 +: 16] = 16'($urandom);
          reqOp[i*2 +: 2] = 2'($urandom);
        end
      end
      rspReady = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (mul_active) begin
        mul_cnt++;
        fpuMulDone = (mul_cnt == mul_d);
      end else begin
        fpuMulDone = noise_en && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: grant model, in-flight checks, response scoreboard
  initial begin : monitor
    logic [NUM_REQ-1:0] exp_rdy;
    int gidx, idx;
    exp_t e;
    logic [23:0] stash;
    bit stalled, prev_valid;
    stalled = 0; prev_valid = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0; prev_valid = 0;
      end else begin
        exp_rdy = '0; gidx = -1;
        if (!busy) begin
          for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (last + k) % NUM_REQ;
            if (gidx < 0 && reqValid[idx]) gidx = idx;
          end
        end
        if (gidx >= 0) exp_rdy[gidx] = 1'b1;
        check("grant", 64'(reqReady), 64'(exp_rdy));

        if (busy && sb_q.size() != 0) begin
          if (fpuStart) cur_starts++;
          if ({fpuIn1, fpuIn2, fpuOp} !== {sb_q[0].a, sb_q[0].b, sb_q[0].op}) hold_bad = 1'b1;
        end
        if (fpuStart) begin mul_active = 1'b1; mul_cnt = 0; end

        if (rspValid) begin
          if (sb_q.size() == 0) begin
            check("rsp_unexpected", 64'(rspValid), 64'd0);
          end else begin
            if (!prev_valid) check("latency", 64'(cyc - acc_cyc), 64'(sb_q[0].lat));
            if (stalled) check("rsp_stable", 64'({rspId, rspData, rspFlags, rspErr}), 64'(stash));
            if (rspReady) begin
              e = sb_q.pop_front();
              check("rsp_id", 64'(rspId), 64'(e.id));
              check("rsp_data", 64'(rspData), 64'(e.data));
              check("rsp_flags", 64'(rspFlags), 64'(e.flags));
              check("rsp_err", 64'(rspErr), 64'(e.err));
              check("start_pulses", 64'(cur_starts), 64'(e.nstart));
              check("operand_hold", 64'(hold_bad), 64'd0);
              busy = 1'b0; mul_active = 1'b0; stalled = 0;
            end else begin
              stalled = 1; stash = {rspId, rspData, rspFlags, rspErr};
            end
          end
        end else begin
          if (stalled) check("rsp_dropped", 64'(rspValid), 64'd1);
          stalled = 0;
        end
        prev_valid = rspValid && !rspReady;

        if (gidx >= 0) begin
          sb_q.push_back(mk(gidx, s_a[gidx], s_b[gidx], s_op[gidx], s_d[gidx]));
          busy = 1'b1; last = gidx; taken[gidx] = 1'b1;
          acc_cyc = cyc; cur_starts = 0; hold_bad = 1'b0; mul_d = s_d[gidx];
        end
      end
    end
  end

  initial begin : main
    int t;
    int r;
    logic [1:0] op;
    for (int i = 0; i < NUM_REQ; i++) begin has[i] = 0; taken[i] = 0; s_d[i] = 0; end
    repeat (3) @(posedge clk);
    #3;
    check_reset_outputs("reset_values");
    @(posedge clk); #2;
    rst_n = 1'b1;
    noise_en = 1;

    // single ADD, then a MUL with mulDone 5 cycles after start
    post(0, 16'h3C00, 16'h4000, 2'd0, 0);
    wait_idle();
    post(2, 16'h4000, 16'h4200, 2'd2, 5);
    wait_idle();

    // all four requesting, two rounds: round-robin order checked by the grant model
    repeat (2) begin
      for (int i = 0; i < NUM_REQ; i++) post(i, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 1)), 0);
      wait_idle();
    end

    // response stalled 10 cycles with requester 1 waiting
    rdy_mode = 2;
    post(0, 16'h1234, 16'h5678, 2'd1, 0);
    post(1, 16'h9ABC, 16'hDEF0, 2'd0, 0);
    t = 0;
    while (!rspValid && t < 50) begin @(posedge clk); t++; end
    if (t >= 50) begin n_cmp++; n_bad++; $display("FAIL stall_wait: rspValid never rose"); end
    repeat (10) @(posedge clk);
    rdy_mode = 1;
    wait_idle();

    // MUL timeout, boundary delays, unsupported op
    post(1, 16'h4000, 16'h4400, 2'd2, 0);
    wait_idle();
    post(1, 16'h3800, 16'h4400, 2'd2, MUL_TIMEOUT);
    wait_idle();
    post(3, 16'h3800, 16'h4800, 2'd2, MUL_TIMEOUT + 1);
    wait_idle();
    post(2, 16'h3C00, 16'h3C00, 2'd3, 0);
    wait_idle();

    // reset in the middle of WAIT_MUL
    post(3, 16'h4100, 16'h4200, 2'd2, 0);
    t = 0;
    while (!(busy && (cyc - acc_cyc) >= 10) && t < 100) begin @(posedge clk); t++; end
    if (t >= 100) begin n_cmp++; n_bad++; $display("FAIL reset_wait: MUL never accepted"); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset_values");
    sb_q.delete(); busy = 0; last = NUM_REQ - 1; mul_active = 0;
    for (int i = 0; i < NUM_REQ; i++) begin has[i] = 0; taken[i] = 0; end
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    post(3, 16'h2222, 16'h3333, 2'd0, 0);
    wait_idle();
    for (int i = 0; i < NUM_REQ; i++) post(i, 16'($urandom), 16'($urandom), 2'd1, 0);
    wait_idle();

    // randomized traffic with random backpressure and withdrawals
    rdy_mode = 0; withdraw_en = 1;
    repeat (500) begin
      @(posedge clk); #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!has[i] && !taken[i] && $urandom_range(0, 5) == 0) begin
          r = $urandom_range(0, 9);
          op = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
          post(i, 16'($urandom), 16'($urandom), op,
               ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 10));
        end
      end
    end
    withdraw_en = 0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
